tx_stuff_seq: RTL and testbench
===============================

# tx_stuff_seq

Transmit bit-stuffing and CRC-phase sequencer for the CAN transmit path. The block sits directly downstream of the transmit CRC generator and the transmit message shift register. It selects the serial source: message bits, or the 15-bit CRC while `crc_phase` is high. After five equal consecutive bits it inserts a complementary stuff bit, and it issues one-clock advance pulses that drive the upstream `activ`/`load_activ` inputs. It also signals the end of the CRC sequence, including a trailing stuff bit.

## Interface
- `STUFF_LIMIT`, default 5: number of equal consecutive bits that forces a stuff bit.
- `CRC_LEN`, default 15: number of CRC bits consumed in the CRC phase.
- `clock`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: reset, synchronous, active-low.
- `tx_point`  in  1: one-clock strobe, once per bit time; transmit bit boundary.
- `stuff_en`  in  1: stuffing active, from SOF through the last CRC bit and any trailing stuff bit.
- `crc_phase`  in  1: source select; 1 selects `crc_bit`, 0 selects `msg_bit`.
- `msg_bit`  in  1: serial bit from the message shift register.
- `crc_bit`  in  1: serial CRC bit (`crc_tosend` of the CRC generator).
- `tx_bit`  out  1: bit driven to the bus; 1 = recessive.
- `stuff_bit`  out  1: high for the whole bit time in which a stuff bit is on `tx_bit`.
- `shift_req`  out  1: one-clock pulse; upstream source advances one bit.
- `crc_done`  out  1: one-clock pulse; CRC sequence complete, including any trailing stuff bit.

## Operation
- Internal state:
  - `last_bit` (1 bit).
  - `run_cnt` (3 bits, range 0..STUFF_LIMIT).
  - `crc_cnt` (4 bits, range 0..CRC_LEN).
  - `done_pend` (1 bit).
- On a `tx_point` clock with `stuff_en`=1 and `run_cnt`=STUFF_LIMIT, a stuff bit is sent:
  - `tx_bit` <= ~`last_bit`; `last_bit` <= ~`last_bit`; `run_cnt` <= 1; `stuff_bit` <= 1.
  - No `shift_req`; `crc_cnt` is unchanged.
- On a `tx_point` clock with `stuff_en`=1 and `run_cnt`<STUFF_LIMIT, a data bit is sent:
  - b = `crc_phase` ? `crc_bit` : `msg_bit`.
  - `tx_bit` <= b; `stuff_bit` <= 0.
  - `run_cnt` <= (b==`last_bit` && `run_cnt`!=0) ? `run_cnt`+1 : 1; `last_bit` <= b.
  - `shift_req` pulses.
  - If `crc_phase`=1, `crc_cnt` increments.
- On a `tx_point` clock with `stuff_en`=0:
  - `tx_bit` <= `msg_bit`; `stuff_bit` <= 0; `shift_req` pulses.
  - `run_cnt`, `crc_cnt` <= 0.
- Any clock with `stuff_en`=0 clears `run_cnt`, `crc_cnt` and `done_pend`. No stuff bit is ever inserted after `stuff_en` falls.
- `crc_phase`=0 clears `crc_cnt`.
- When `crc_cnt` reaches CRC_LEN on a data bit:
  - If the resulting `run_cnt`<STUFF_LIMIT, `crc_done` pulses.
  - Otherwise `done_pend` is set. `crc_done` pulses after the next `tx_point`, which sends the stuff bit, and `done_pend` clears.
- `crc_cnt` saturates at CRC_LEN. Further `crc_phase` data bits do not pulse `crc_done` again.
- Reset (`reset`=0 at a clock edge):
  - `tx_bit`=1; `stuff_bit`=0; `shift_req`=0; `crc_done`=0.
  - `last_bit`=1; `run_cnt`=0; `crc_cnt`=0; `done_pend`=0.
  - Reset overrides a simultaneous `tx_point`.

## Timing
- `tx_bit` and `stuff_bit` are registered and change on the rising edge where `tx_point`=1.
- `shift_req` is high for exactly the one clock following that edge. Upstream samples it at the next edge, so the new source bit is stable before the next `tx_point`.
- `crc_done` is high for the one clock following the edge that sent the last CRC bit or its trailing stuff bit.
- Minimum `tx_point` spacing is 3 clocks; closer spacing is a usage error.
- `stuff_en`, `crc_phase` and the data inputs are sampled only on `tx_point` clocks, except that the clears above apply on every clock.
- `crc_bit`/`msg_bit` must be stable for at least 1 clock before `tx_point`.

## Structure
- Shared package `can_tx_pkg`: constants `STUFF_LIMIT`=5 and `CRC_LEN`=15. The CRC generator and frame controller also use it.
- One natural sub-module: `stuff_run_cnt`, the run counter with equality compare and limit flag. Everything else stays inline.

## Test plan
- **Reset:** drive `reset`=0 for 2 clocks mid-frame, with `run_cnt` at 4 and `tx_point` coincident -> `tx_bit`=1, all pulses 0, next frame's first bit has `run_cnt`=1.
- **Stuff after five dominant:** `stuff_en`=1, `msg_bit`=0 for 6 `tx_point`s -> `tx_bit` 0,0,0,0,0,1, `stuff_bit` high on the 6th, `shift_req` on points 1-5 only.
- **Stuff bit starts a new run:** after the stuff bit=1, send 4×`msg_bit`=1 -> the next point is a stuff 0 (run of 5 = stuff + 4).
- **CRC phase:** 15 CRC bits 101010101010101 -> 15 `shift_req`, no stuff bits, `crc_done` one clock after the 15th point.
- **Trailing stuff:** CRC ending in 5×1, with `run_cnt`=5 after bit 15 -> `crc_done` withheld, next point sends stuff 0, then `crc_done` pulses.
- **stuff_en falls:** drop `stuff_en` with `run_cnt`=5 -> next point sends `msg_bit` (no stuff), `shift_req` pulses, `stuff_bit`=0.

Source files
------------

// File: rtl/can_tx_pkg.sv
// can_tx_pkg: constants shared by the CAN transmit path (CRC generator, frame
// controller, stuff sequencer).
//   STUFF_LIMIT : equal consecutive bits that force a stuff bit
//   CRC_LEN     : CRC bits sent in the CRC phase
//   bit_kind_e  : what the sequencer does on a given clock
package can_tx_pkg;

    localparam int unsigned STUFF_LIMIT = 5;
    localparam int unsigned CRC_LEN     = 15;

    typedef enum logic [1:0] {
        BitIdle,   // no tx_point this clock
        BitRaw,    // tx_point with stuffing off: pass msg_bit through
        BitData,   // tx_point, stuffing on, source bit sent
        BitStuff   // tx_point, stuffing on, complementary stuff bit sent
    } bit_kind_e;

endpackage

// File: rtl/stuff_run_cnt.sv
// stuff_run_cnt: run-length counter for bit stuffing.
// Counts equal consecutive bits on the wire (stuff bits included) and flags
// when the limit is reached.
//   clock, reset  : clock, synchronous active-low reset
//   clear_i       : clear count (stuffing inactive)
//   stuff_i       : a stuff bit is being sent; it starts a new run of 1
//   data_i        : a data bit bit_i is being sent
//   bit_i         : data bit value
//   last_bit_i    : previous bit on the wire
//   at_limit_o    : current run has reached STUFF_LIMIT (next point stuffs)
//   hits_limit_o  : sending bit_i as data would bring the run to STUFF_LIMIT
module stuff_run_cnt #(
    parameter int unsigned STUFF_LIMIT = can_tx_pkg::STUFF_LIMIT,
    parameter int unsigned CNT_W       = $clog2(STUFF_LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic stuff_i,
    input  logic data_i,
    input  logic bit_i,
    input  logic last_bit_i,
    output logic at_limit_o,
    output logic hits_limit_o
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(STUFF_LIMIT);
    localparam logic [CNT_W-1:0] One   = CNT_W'(1);

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] run_inc;

    // A count of 0 means no run yet, so the first bit starts at 1 regardless
    // of last_bit.
    assign run_inc      = (bit_i == last_bit_i && run_cnt_q != '0) ? run_cnt_q + One : One;
    assign at_limit_o   = (run_cnt_q == Limit);
    assign hits_limit_o = (run_inc == Limit);

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (clear_i) begin
            run_cnt_d = '0;
        end else if (stuff_i) begin
            run_cnt_d = One;
        end else if (data_i) begin
            run_cnt_d = run_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

endmodule

// File: rtl/tx_stuff_seq.sv
// tx_stuff_seq: transmit bit-stuffing and CRC-phase sequencer.
// Selects message or CRC bits onto the bus, inserts a complementary stuff bit
// after STUFF_LIMIT equal bits, pulses shift_req to advance the upstream
// source and pulses crc_done once the CRC (and any trailing stuff bit) is out.
//   clock, reset : clock, synchronous active-low reset
//   tx_point     : one-clock strobe per bit time
//   stuff_en     : stuffing active (SOF .. last CRC bit / trailing stuff)
//   crc_phase    : 1 selects crc_bit, 0 selects msg_bit
//   msg_bit      : message serial bit
//   crc_bit      : CRC serial bit
//   tx_bit       : bus bit, 1 = recessive (registered)
//   stuff_bit    : high while a stuff bit is on tx_bit (registered)
//   shift_req    : one-clock pulse, upstream advances one bit
//   crc_done     : one-clock pulse, CRC sequence complete
module tx_stuff_seq #(
    parameter int unsigned STUFF_LIMIT = can_tx_pkg::STUFF_LIMIT,
    parameter int unsigned CRC_LEN     = can_tx_pkg::CRC_LEN
) (
    input  logic clock,
    input  logic reset,
    input  logic tx_point,
    input  logic stuff_en,
    input  logic crc_phase,
    input  logic msg_bit,
    input  logic crc_bit,
    output logic tx_bit,
    output logic stuff_bit,
    output logic shift_req,
    output logic crc_done
);

    import can_tx_pkg::bit_kind_e;
    import can_tx_pkg::BitIdle;
    import can_tx_pkg::BitRaw;
    import can_tx_pkg::BitData;
    import can_tx_pkg::BitStuff;

    localparam int unsigned RunW = $clog2(STUFF_LIMIT + 1);
    localparam int unsigned CrcW = $clog2(CRC_LEN + 1);
    localparam logic [CrcW-1:0] CrcMax  = CrcW'(CRC_LEN);
    localparam logic [CrcW-1:0] CrcLast = CrcW'(CRC_LEN - 1);
    localparam logic [CrcW-1:0] CrcOne  = CrcW'(1);

    logic            tx_bit_q,    tx_bit_d;
    logic            stuff_bit_q, stuff_bit_d;
    logic            shift_req_q, shift_req_d;
    logic            crc_done_q,  crc_done_d;
    logic            last_bit_q,  last_bit_d;
    logic [CrcW-1:0] crc_cnt_q,   crc_cnt_d;
    logic            done_pend_q, done_pend_d;

    logic      src_bit;
    logic      at_limit;
    logic      hits_limit;
    bit_kind_e kind;

    assign src_bit = crc_phase ? crc_bit : msg_bit;

    always_comb begin
        kind = BitIdle;
        if (tx_point) begin
            if (!stuff_en) begin
                kind = BitRaw;
            end else if (at_limit) begin
                kind = BitStuff;
            end else begin
                kind = BitData;
            end
        end
    end

    stuff_run_cnt #(
        .STUFF_LIMIT (STUFF_LIMIT),
        .CNT_W       (RunW)
    ) u_run_cnt (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (!stuff_en),
        .stuff_i      (kind == BitStuff),
        .data_i       (kind == BitData),
        .bit_i        (src_bit),
        .last_bit_i   (last_bit_q),
        .at_limit_o   (at_limit),
        .hits_limit_o (hits_limit)
    );

    always_comb begin
        tx_bit_d    = tx_bit_q;
        stuff_bit_d = stuff_bit_q;
        last_bit_d  = last_bit_q;
        crc_cnt_d   = crc_cnt_q;
        done_pend_d = done_pend_q;
        shift_req_d = 1'b0;
        crc_done_d  = 1'b0;

        unique case (kind)
            BitIdle: ;
            BitRaw: begin
                tx_bit_d    = msg_bit;
                stuff_bit_d = 1'b0;
                shift_req_d = 1'b1;
            end
            BitStuff: begin
                tx_bit_d    = ~last_bit_q;
                last_bit_d  = ~last_bit_q;
                stuff_bit_d = 1'b1;
                // Trailing stuff bit after the last CRC bit completes the CRC.
                if (done_pend_q) begin
                    crc_done_d  = 1'b1;
                    done_pend_d = 1'b0;
                end
            end
            BitData: begin
                tx_bit_d    = src_bit;
                last_bit_d  = src_bit;
                stuff_bit_d = 1'b0;
                shift_req_d = 1'b1;
                // Saturating count; only the crossing into CRC_LEN signals done.
                if (crc_phase && crc_cnt_q != CrcMax) begin
                    crc_cnt_d = crc_cnt_q + CrcOne;
                    if (crc_cnt_q == CrcLast) begin
                        if (hits_limit) begin
                            done_pend_d = 1'b1;
                        end else begin
                            crc_done_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        // These clears hold on every clock, not just on tx_point.
        if (!stuff_en) begin
            crc_cnt_d   = '0;
            done_pend_d = 1'b0;
        end
        if (!crc_phase) begin
            crc_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_bit_q    <= 1'b1;
            stuff_bit_q <= 1'b0;
            shift_req_q <= 1'b0;
            crc_done_q  <= 1'b0;
            last_bit_q  <= 1'b1;
            crc_cnt_q   <= '0;
            done_pend_q <= 1'b0;
        end else begin
            tx_bit_q    <= tx_bit_d;
            stuff_bit_q <= stuff_bit_d;
            shift_req_q <= shift_req_d;
            crc_done_q  <= crc_done_d;
            last_bit_q  <= last_bit_d;
            crc_cnt_q   <= crc_cnt_d;
            done_pend_q <= done_pend_d;
        end
    end

    assign tx_bit    = tx_bit_q;
    assign stuff_bit = stuff_bit_q;
    assign shift_req = shift_req_q;
    assign crc_done  = crc_done_q;

endmodule

// File: tb/tb_tx_stuff_seq.sv
// tb_tx_stuff_seq: self-checking bench for tx_stuff_seq. Directed scenarios
// with constant expectations, plus randomized frames checked against a
// history-based model of the stuffing and CRC-completion rules.
module tb_tx_stuff_seq;

    localparam int unsigned STUFF_LIMIT = 5;
    localparam int unsigned CRC_LEN     = 15;

    logic clock     = 1'b0;
    logic reset     = 1'b0;
    logic tx_point  = 1'b0;
    logic stuff_en  = 1'b0;
    logic crc_phase = 1'b0;
    logic msg_bit   = 1'b1;
    logic crc_bit   = 1'b1;
    logic tx_bit, stuff_bit, shift_req, crc_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Outputs one clock after a tx_point edge, and one clock after that.
    logic obs_tx, obs_stuff, obs_shift, obs_done, obs_shift2, obs_done2;

    // Reference model: bits on the wire since stuffing started.
    bit hist[$];
    int m_crc;
    bit m_pend;

    tx_stuff_seq #(
        .STUFF_LIMIT (STUFF_LIMIT),
        .CRC_LEN     (CRC_LEN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tx_point  (tx_point),
        .stuff_en  (stuff_en),
        .crc_phase (crc_phase),
        .msg_bit   (msg_bit),
        .crc_bit   (crc_bit),
        .tx_bit    (tx_bit),
        .stuff_bit (stuff_bit),
        .shift_req (shift_req),
        .crc_done  (crc_done)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clock);
        reset    = 1'b0;
        tx_point = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One bit time: inputs stable a clock before the strobe, 4-clock spacing.
    task automatic do_point(input logic se, input logic cp, input logic mb, input logic cb);
        @(negedge clock);
        stuff_en  = se;
        crc_phase = cp;
        msg_bit   = mb;
        crc_bit   = cb;
        tx_point  = 1'b0;
        @(negedge clock);
        tx_point = 1'b1;
        @(negedge clock);
        tx_point  = 1'b0;
        obs_tx    = tx_bit;
        obs_stuff = stuff_bit;
        obs_shift = shift_req;
        obs_done  = crc_done;
        @(negedge clock);
        obs_shift2 = shift_req;
        obs_done2  = crc_done;
    endtask

    function automatic bit need_stuff();
        int n;
        n = hist.size();
        if (n < int'(STUFF_LIMIT)) return 1'b0;
        for (int k = 1; k < int'(STUFF_LIMIT); k++) begin
            if (hist[n-1-k] != hist[n-1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_crc  = 0;
        m_pend = 1'b0;
    endtask

    task automatic model_point(input bit se, input bit cp, input bit mb, input bit cb,
                               output bit etx, output bit estuff, output bit eshift,
                               output bit edone);
        bit b;
        edone = 1'b0;
        if (!se) begin
            etx    = mb;
            estuff = 1'b0;
            eshift = 1'b1;
            model_reset();
            return;
        end
        if (!cp) m_crc = 0;
        if (need_stuff()) begin
            etx    = ~hist[hist.size()-1];
            estuff = 1'b1;
            eshift = 1'b0;
            hist.push_back(etx);
            if (m_pend) begin
                edone  = 1'b1;
                m_pend = 1'b0;
            end
        end else begin
            b      = cp ? cb : mb;
            etx    = b;
            estuff = 1'b0;
            eshift = 1'b1;
            hist.push_back(b);
            if (cp && m_crc < int'(CRC_LEN)) begin
                m_crc++;
                if (m_crc == int'(CRC_LEN)) begin
                    if (need_stuff()) m_pend = 1'b1;
                    else edone = 1'b1;
                end
            end
        end
        if (hist.size() > int'(STUFF_LIMIT)) void'(hist.pop_front());
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests += 4;
        if (tx_bit !== 1'b1) begin
            n_fail++; $display("FAIL reset_tx: got %b want 1", tx_bit);
        end
        if (stuff_bit !== 1'b0) begin
            n_fail++; $display("FAIL reset_stuff: got %b want 0", stuff_bit);
        end
        if (shift_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_shift: got %b want 0", shift_req);
        end
        if (crc_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", crc_done);
        end
        // Build a run of 4 dominant bits, then reset with a coincident tx_point.
        for (int i = 0; i < 4; i++) do_point(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset    = 1'b0;
        msg_bit  = 1'b0;
        tx_point = 1'b1;
        @(negedge clock);
        tx_point = 1'b0;
        n_tests += 3;
        if (tx_bit !== 1'b1) begin
            n_fail++; $display("FAIL midreset_tx: got %b want 1", tx_bit);
        end
        if (shift_req !== 1'b0 || crc_done !== 1'b0) begin
            n_fail++; $display("FAIL midreset_pulses: shift %b done %b want 0 0", shift_req, crc_done);
        end
        if (stuff_bit !== 1'b0) begin
            n_fail++; $display("FAIL midreset_stuff: got %b want 0", stuff_bit);
        end
        @(negedge clock);
        reset = 1'b1;
        // Fresh run: five data bits then a stuff bit.
        for (int i = 1; i <= 6; i++) begin
            do_point(1'b1, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs_stuff !== (i == 6) || obs_tx !== (i == 6)) begin
                n_fail++;
                $display("FAIL postreset_run[%0d]: tx %b stuff %b want tx %b stuff %b",
                         i, obs_tx, obs_stuff, i == 6, i == 6);
            end
        end
        do_point(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_stuff_dominant();
        do_point(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            do_point(1'b1, 1'b0, 1'b0, 1'b1);
            n_tests += 2;
            if (obs_tx !== (i == 6) || obs_stuff !== (i == 6)) begin
                n_fail++;
                $display("FAIL dom_bit[%0d]: tx %b stuff %b want tx %b stuff %b",
                         i, obs_tx, obs_stuff, i == 6, i == 6);
            end
            if (obs_shift !== (i != 6) || obs_shift2 !== 1'b0) begin
                n_fail++;
                $display("FAIL dom_shift[%0d]: shift %b then %b want %b then 0",
                         i, obs_shift, obs_shift2, i != 6);
            end
        end
    endtask

    // Continues from test_stuff_dominant: the stuff 1 counts toward the next run.
    task automatic test_stuff_new_run();
        for (int i = 1; i <= 4; i++) begin
            do_point(1'b1, 1'b0, 1'b1, 1'b0);
            n_tests++;
            if (obs_tx !== 1'b1 || obs_stuff !== 1'b0 || obs_shift !== 1'b1) begin
                n_fail++;
                $display("FAIL newrun_bit[%0d]: tx %b stuff %b shift %b want 1 0 1",
                         i, obs_tx, obs_stuff, obs_shift);
            end
        end
        do_point(1'b1, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (obs_tx !== 1'b0 || obs_stuff !== 1'b1 || obs_shift !== 1'b0) begin
            n_fail++;
            $display("FAIL newrun_stuff: tx %b stuff %b shift %b want 0 1 0",
                     obs_tx, obs_stuff, obs_shift);
        end
        do_point(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_crc_phase();
        logic cb;
        do_point(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cb = (i % 2 == 0);
            do_point(1'b1, 1'b1, ~cb, cb);
            n_tests += 2;
            if (obs_tx !== cb || obs_stuff !== 1'b0 || obs_shift !== 1'b1) begin
                n_fail++;
                $display("FAIL crc_bit[%0d]: tx %b stuff %b shift %b want %b 0 1",
                         i, obs_tx, obs_stuff, obs_shift, cb);
            end
            if (obs_done !== (i == 14) || obs_done2 !== 1'b0) begin
                n_fail++;
                $display("FAIL crc_done[%0d]: got %b then %b want %b then 0",
                         i, obs_done, obs_done2, i == 14);
            end
        end
        do_point(1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (obs_done !== 1'b0) begin
            n_fail++; $display("FAIL crc_saturate: done %b want 0", obs_done);
        end
        do_point(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_trailing_stuff();
        logic cb;
        do_point(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cb = (i < 10) ? (i % 2 == 0) : 1'b1;
            do_point(1'b1, 1'b1, 1'b0, cb);
            n_tests++;
            if (obs_tx !== cb || obs_stuff !== 1'b0 || obs_done !== 1'b0) begin
                n_fail++;
                $display("FAIL trail_bit[%0d]: tx %b stuff %b done %b want %b 0 0",
                         i, obs_tx, obs_stuff, obs_done, cb);
            end
        end
        do_point(1'b1, 1'b1, 1'b1, 1'b1);
        n_tests += 2;
        if (obs_tx !== 1'b0 || obs_stuff !== 1'b1 || obs_shift !== 1'b0) begin
            n_fail++;
            $display("FAIL trail_stuff: tx %b stuff %b shift %b want 0 1 0",
                     obs_tx, obs_stuff, obs_shift);
        end
        if (obs_done !== 1'b1 || obs_done2 !== 1'b0) begin
            n_fail++;
            $display("FAIL trail_done: got %b then %b want 1 then 0", obs_done, obs_done2);
        end
        do_point(1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_done !== 1'b0) begin
            n_fail++; $display("FAIL trail_redone: done %b want 0", obs_done);
        end
        do_point(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_stuff_en_fall();
        do_point(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) do_point(1'b1, 1'b0, 1'b0, 1'b0);
        do_point(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (obs_tx !== 1'b0 || obs_stuff !== 1'b0 || obs_shift !== 1'b1) begin
            n_fail++;
            $display("FAIL enfall: tx %b stuff %b shift %b want 0 0 1",
                     obs_tx, obs_stuff, obs_shift);
        end
    endtask

    task automatic test_random_frames();
        bit se_q[$], cp_q[$], mb_q[$], cb_q[$];
        bit prev, b, etx, estuff, eshift, edone;
        int n_msg, n_crc, n_off;
        apply_reset();
        model_reset();
        prev = 1'b1;
        for (int f = 0; f < 25; f++) begin
            se_q.delete(); cp_q.delete(); mb_q.delete(); cb_q.delete();
            n_msg = int'($urandom_range(3, 25));
            n_crc = int'($urandom_range(15, 17));
            n_off = int'($urandom_range(1, 3));
            for (int i = 0; i < n_msg + n_crc + n_off; i++) begin
                // Biased toward repeats so runs of five occur often.
                b    = ($urandom_range(0, 3) == 0) ? ~prev : prev;
                prev = b;
                se_q.push_back(i < n_msg + n_crc);
                cp_q.push_back(i >= n_msg && i < n_msg + n_crc);
                if (i >= n_msg && i < n_msg + n_crc) begin
                    cb_q.push_back(b);
                    mb_q.push_back(1'($urandom_range(0, 1)));
                end else begin
                    mb_q.push_back(b);
                    cb_q.push_back(1'($urandom_range(0, 1)));
                end
            end
            for (int i = 0; i < se_q.size(); i++) begin
                model_point(se_q[i], cp_q[i], mb_q[i], cb_q[i], etx, estuff, eshift, edone);
                do_point(se_q[i], cp_q[i], mb_q[i], cb_q[i]);
                n_tests++;
                if (obs_tx !== etx || obs_stuff !== estuff || obs_shift !== eshift ||
                    obs_done !== edone || obs_shift2 !== 1'b0 || obs_done2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand[%0d.%0d]: tx %b stuff %b shift %b done %b (%b %b) want %b %b %b %b (0 0)",
                             f, i, obs_tx, obs_stuff, obs_shift, obs_done, obs_shift2,
                             obs_done2, etx, estuff, eshift, edone);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stuff_dominant();
        test_stuff_new_run();
        test_crc_phase();
        test_trailing_stuff();
        test_stuff_en_fall();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
